// File: rtl/keypad_pkg.sv
// Shared types and constants for the keypad history scanner.
package keypad_pkg;

  localparam int unsigned KeyW = 4;

  typedef enum logic [1:0] {
    StScan,
    StPressDb,
    StHold,
    StReleaseDb
  } state_e;

  // Indexed [row][col] for the standard 4x4 telephone-style pad.
  localparam logic [KeyW-1:0] KeyMap [4][4] = '{
    '{4'hA, 4'h0, 4'hB, 4'hF},
    '{4'h7, 4'h8, 4'h9, 4'hE},
    '{4'h4, 4'h5, 4'h6, 4'hD},
    '{4'h1, 4'h2, 4'h3, 4'hC}
  };

endpackage

// File: rtl/debounce_counter.sv
// Saturating stability counter; done marks the enabled cycle that completes LIMIT cycles.
module debounce_counter #(
  parameter int unsigned LIMIT = 20000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic done
);

  localparam int unsigned CntW = $clog2(LIMIT + 1);

  logic [CntW-1:0] count_q;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count_q <= '0;
    end else if (enable && (count_q != CntW'(LIMIT))) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign done = enable && (count_q >= CntW'(LIMIT - 1));

endmodule

// File: rtl/keypad_history_scanner.sv
// Column-scanning keypad controller with press/release debounce and a short code history.
module keypad_history_scanner
  import keypad_pkg::*;
#(
  parameter int unsigned ROWS            = 4,
  parameter int unsigned COLS            = 4,
  parameter int unsigned SCAN_DIV        = 1000,
  parameter int unsigned DEBOUNCE_CYCLES = 20000,
  parameter int unsigned HIST_DEPTH      = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [ROWS-1:0]            row_in,
  output logic [COLS-1:0]            col_drive,
  output logic [KeyW-1:0]            key_code,
  output logic                       key_valid,
  output logic [KeyW*HIST_DEPTH-1:0] history,
  output logic                       multi_key,
  output logic                       busy
);

  localparam int unsigned ScanW = $clog2(SCAN_DIV);
  localparam int unsigned ColW  = $clog2(COLS);
  localparam int unsigned HistW = KeyW * HIST_DEPTH;

  state_e                state_q, state_d;
  logic [ROWS-1:0]       rs_meta_q, rs_q;
  logic [ROWS-1:0]       rows_q, rows_d;
  logic [ScanW-1:0]      scan_cnt_q, scan_cnt_d;
  logic [ColW-1:0]       col_q, col_d, col_inc;
  logic [KeyW-1:0]       key_code_q, key_code_d, new_code;
  logic [HistW-1:0]      history_q, history_d;
  logic                  key_valid_q, key_valid_d;
  logic                  multi_key_q, multi_key_d;
  logic [1:0]            row_idx;
  logic                  db_clear, db_enable, db_done;

  debounce_counter #(
    .LIMIT (DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk    (clk),
    .reset  (reset),
    .clear  (db_clear),
    .enable (db_enable),
    .done   (db_done)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StScan;
      rs_meta_q   <= '0;
      rs_q        <= '0;
      rows_q      <= '0;
      scan_cnt_q  <= '0;
      col_q       <= '0;
      key_code_q  <= '0;
      history_q   <= '0;
      key_valid_q <= 1'b0;
      multi_key_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rs_meta_q   <= row_in;
      rs_q        <= rs_meta_q;
      rows_q      <= rows_d;
      scan_cnt_q  <= scan_cnt_d;
      col_q       <= col_d;
      key_code_q  <= key_code_d;
      history_q   <= history_d;
      key_valid_q <= key_valid_d;
      multi_key_q <= multi_key_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    db_clear  = 1'b0;
    db_enable = 1'b0;
    unique case (state_q)
      StScan: begin
        if (rs_q != '0) begin
          state_d  = StPressDb;
          db_clear = 1'b1;
        end
      end
      StPressDb: begin
        if (rs_q != rows_q) begin
          state_d  = StScan;
          db_clear = 1'b1;
        end else begin
          db_enable = 1'b1;
          if (db_done) state_d = StHold;
        end
      end
      StHold: begin
        if (rs_q == '0) begin
          state_d  = StReleaseDb;
          db_clear = 1'b1;
        end
      end
      StReleaseDb: begin
        if (rs_q != '0) begin
          state_d = StHold;
        end else begin
          db_enable = 1'b1;
          if (db_done) state_d = StScan;
        end
      end
      default: state_d = StScan;
    endcase
  end

  // Key code from the latched row (one-hot) and frozen column.
  always_comb begin
    row_idx = '0;
    for (int i = 0; i < ROWS; i++) begin
      if (rows_q[i]) row_idx = 2'(i);
    end
    if (ROWS == 4 && COLS == 4) begin
      new_code = KeyMap[row_idx][2'(col_q)];
    end else begin
      new_code = KeyW'(32'(row_idx) * COLS + 32'(col_q));
    end
    col_inc = (col_q == ColW'(COLS - 1)) ? '0 : col_q + 1'b1;
  end

  always_comb begin
    rows_d      = rows_q;
    scan_cnt_d  = scan_cnt_q;
    col_d       = col_q;
    key_code_d  = key_code_q;
    history_d   = history_q;
    key_valid_d = 1'b0;
    multi_key_d = 1'b0;
    unique case (state_q)
      StScan: begin
        if (rs_q != '0) begin
          rows_d     = rs_q;
          scan_cnt_d = '0;
        end else if (scan_cnt_q == ScanW'(SCAN_DIV - 1)) begin
          scan_cnt_d = '0;
          col_d      = col_inc;
        end else begin
          scan_cnt_d = scan_cnt_q + 1'b1;
        end
      end
      StPressDb: begin
        if ((rs_q == rows_q) && db_done) begin
          if ($onehot(rows_q)) begin
            key_code_d  = new_code;
            history_d   = (history_q << KeyW) | HistW'(new_code);
            key_valid_d = 1'b1;
          end else begin
            multi_key_d = 1'b1;
          end
        end
      end
      StReleaseDb: begin
        if ((rs_q == '0) && db_done) col_d = col_inc;
      end
      default: ;
    endcase
  end

  always_comb begin
    col_drive        = '0;
    col_drive[col_q] = 1'b1;
    busy             = (state_q != StScan);
    key_code         = key_code_q;
    history          = history_q;
    key_valid        = key_valid_q;
    multi_key        = multi_key_q;
  end

endmodule

// File: tb/tb_keypad_history_scanner.sv
// Directed bench: keypad matrix model, scoreboard of accepted codes, pulse counting.
module tb_keypad_history_scanner;

  localparam int unsigned ROWS = 4;
  localparam int unsigned COLS = 4;
  localparam int unsigned SDIV = 4;
  localparam int unsigned DB   = 8;
  localparam int unsigned HD   = 2;

  typedef struct {
    logic [3:0] code;
    logic [7:0] hist;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] row_in;
  logic [3:0] col_drive;
  logic [3:0] key_code;
  logic       key_valid;
  logic [7:0] history;
  logic       multi_key;
  logic       busy;

  logic [3:0]  pressed [4];
  logic [15:0] map_row [4];
  exp_t        sb [$];
  logic [7:0]  model_hist;
  int          total = 0;
  int          bad = 0;
  int          n_valid = 0;
  int          n_multi = 0;

  keypad_history_scanner #(
    .ROWS            (ROWS),
    .COLS            (COLS),
    .SCAN_DIV        (SDIV),
    .DEBOUNCE_CYCLES (DB),
    .HIST_DEPTH      (HD)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .row_in    (row_in),
    .col_drive (col_drive),
    .key_code  (key_code),
    .key_valid (key_valid),
    .history   (history),
    .multi_key (multi_key),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // A pressed switch connects its row to its column only while that column is driven.
  always_comb begin
    row_in = '0;
    for (int r = 0; r < 4; r++) row_in[r] = |(pressed[r] & col_drive);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] exp_code(input int r, input int c);
    logic [15:0] w;
    w = map_row[r];
    return w[(3 - c) * 4 +: 4];
  endfunction

  task automatic tick();
    exp_t e;
    @(negedge clk);
    if (key_valid === 1'b1) begin
      n_valid++;
      check("sb_depth_on_valid", sb.size(), 1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("valid_key_code", key_code, e.code);
        check("valid_history", history, e.hist);
      end
    end
    if (multi_key === 1'b1) n_multi++;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_valid(input int v0, input string tag);
    int k;
    k = 0;
    while (n_valid == v0 && k < 100) begin
      tick();
      k++;
    end
    check(tag, n_valid - v0, 1);
  endtask

  task automatic press_key(input int r, input int c, input string tag);
    int v0;
    exp_t e;
    v0 = n_valid;
    model_hist = {model_hist[3:0], exp_code(r, c)};
    e.code = exp_code(r, c);
    e.hist = model_hist;
    sb.push_back(e);
    pressed[r][c] = 1'b1;
    wait_valid(v0, {tag, "_detect"});
    ticks(30);
    check({tag, "_single_valid"}, n_valid - v0, 1);
    pressed[r][c] = 1'b0;
    ticks(40);
    check({tag, "_idle_after"}, busy, 0);
  endtask

  initial begin
    int v0, m0, k;
    logic saw_busy;
    map_row[0] = 16'hA0BF;
    map_row[1] = 16'h789E;
    map_row[2] = 16'h456D;
    map_row[3] = 16'h123C;
    for (int r = 0; r < 4; r++) pressed[r] = '0;
    model_hist = '0;

    // Reset state
    reset = 1'b1;
    ticks(4);
    check("rst_col_drive", col_drive, 4'b0001);
    check("rst_key_code", key_code, 0);
    check("rst_history", history, 0);
    check("rst_key_valid", key_valid, 0);
    check("rst_multi_key", multi_key, 0);
    check("rst_busy", busy, 0);

    // Column walk with no keys
    reset = 1'b0;
    check("scan_col0", col_drive, 4'b0001);
    for (int i = 1; i <= 4; i++) begin
      ticks(SDIV);
      check($sformatf("scan_col_step%0d", i), col_drive, 32'(1 << (i % 4)));
    end

    // Row 1, column 2 held long -> code 9
    press_key(1, 2, "key9");
    check("key9_code", key_code, 4'h9);
    check("key9_history", history, 8'h09);

    // Short bounce on row 0 in column 1: no acceptance, resumes column 1
    k = 0;
    while (col_drive == 4'b0010 && k < 40) begin tick(); k++; end
    k = 0;
    while (col_drive != 4'b0010 && k < 40) begin tick(); k++; end
    v0 = n_valid;
    m0 = n_multi;
    saw_busy = 1'b0;
    pressed[0][1] = 1'b1;
    for (int i = 0; i < DB - 1; i++) begin
      tick();
      if (busy) saw_busy = 1'b1;
    end
    pressed[0][1] = 1'b0;
    k = 0;
    while (busy && k < 20) begin tick(); k++; end
    check("bounce_entered_debounce", saw_busy, 1);
    check("bounce_back_to_scan", busy, 0);
    check("bounce_same_column", col_drive, 4'b0010);
    ticks(20);
    check("bounce_no_valid", n_valid - v0, 0);
    check("bounce_no_multi", n_multi - m0, 0);
    check("bounce_history_kept", history, 8'h09);

    // Keys 1, 2, 3 in sequence
    v0 = n_valid;
    press_key(3, 0, "key1");
    press_key(3, 1, "key2");
    press_key(3, 2, "key3");
    check("seq_valid_count", n_valid - v0, 3);
    check("seq_history", history, 8'h23);

    // Rows 0 and 2 together in column 0
    v0 = n_valid;
    m0 = n_multi;
    pressed[0][0] = 1'b1;
    pressed[2][0] = 1'b1;
    k = 0;
    while (n_multi == m0 && k < 100) begin tick(); k++; end
    check("multi_detect", n_multi - m0, 1);
    ticks(30);
    pressed[0][0] = 1'b0;
    pressed[2][0] = 1'b0;
    ticks(40);
    check("multi_single_pulse", n_multi - m0, 1);
    check("multi_no_valid", n_valid - v0, 0);
    check("multi_history_kept", history, 8'h23);
    check("multi_code_kept", key_code, 4'h3);

    // Reset while holding a key
    v0 = n_valid;
    model_hist = {model_hist[3:0], 4'h9};
    sb.push_back('{code: 4'h9, hist: model_hist});
    pressed[1][2] = 1'b1;
    wait_valid(v0, "hold_detect");
    ticks(5);
    check("hold_busy", busy, 1);
    reset = 1'b1;
    tick();
    check("hold_rst_busy", busy, 0);
    check("hold_rst_col", col_drive, 4'b0001);
    check("hold_rst_history", history, 0);
    check("hold_rst_code", key_code, 0);
    check("hold_rst_valid", key_valid, 0);
    check("hold_rst_multi", multi_key, 0);
    pressed[1][2] = 1'b0;
    model_hist = '0;
    v0 = n_valid;
    m0 = n_multi;
    tick();
    reset = 1'b0;
    ticks(40);
    check("post_rst_no_valid", n_valid - v0, 0);
    check("post_rst_no_multi", n_multi - m0, 0);
    check("sb_drained", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/keypad_history_scanner.md
KEYPAD_HISTORY_SCANNER -- requirements
Module: keypad_history_scanner

Interface
REQ-001 Parameter ROWS, default 4, number of keypad row sense lines (legal 2..4).
REQ-002 Parameter COLS, default 4, number of keypad column drive lines (legal 2..4).
REQ-003 Parameter SCAN_DIV, default 1000, clk cycles each column stays driven while scanning (>=2).
REQ-004 Parameter DEBOUNCE_CYCLES, default 20000, consecutive stable cycles required for press and release (>=2).
REQ-005 Parameter HIST_DEPTH, default 2, number of 4-bit key codes retained (1..8).
REQ-006 clk  input  1  clock; all state updates on rising edge.
REQ-007 reset  input  1  reset, synchronous, active-high.
REQ-008 row_in  input  ROWS  asynchronous row sense, active-high, bit i = row i.
REQ-009 col_drive  output  COLS  one-hot column drive, bit j = column j.
REQ-010 key_code  output  4  code of most recent accepted key.
REQ-011 key_valid  output  1  one-cycle pulse when a key is accepted.
REQ-012 history  output  4*HIST_DEPTH  accepted codes, newest in [3:0], oldest in top nibble.
REQ-013 multi_key  output  1  one-cycle pulse when a debounced press has more than one row bit set.
REQ-014 busy  output  1  high in any state other than SCAN.

Function
REQ-015 row_in SHALL pass through a 2-flop synchronizer; all logic below uses the synchronized value rs.
REQ-016 FSM states SHALL be SCAN, PRESS_DB, HOLD, RELEASE_DB.
REQ-017 SCAN: col_drive advances one-hot every SCAN_DIV cycles, wrapping from bit COLS-1 to bit 0.
REQ-018 SCAN with rs != 0: latch rs and current column index, clear debounce counter, go PRESS_DB; col_drive frozen.
REQ-019 PRESS_DB: counter increments each cycle rs equals the latched rows; any change (including to 0) returns to SCAN with counter cleared and column unchanged.
REQ-020 PRESS_DB after DEBOUNCE_CYCLES stable cycles, one-hot rows: key_code updated, history shifted left by one nibble with new code in [3:0], key_valid high for exactly that cycle, go HOLD.
REQ-021 PRESS_DB after DEBOUNCE_CYCLES stable cycles, multi-hot rows: multi_key pulse one cycle, key_code and history unchanged, go HOLD.
REQ-022 HOLD: col_drive frozen; stays while rs != 0; rs == 0 goes RELEASE_DB with counter cleared.
REQ-023 RELEASE_DB: counter increments each cycle rs == 0; any rs != 0 returns to HOLD; after DEBOUNCE_CYCLES cycles go SCAN, advancing column by one.
REQ-024 A held key SHALL produce exactly one key_valid regardless of hold duration.
REQ-025 Key code for ROWS=COLS=4 SHALL follow KEYMAP: row0 {A,0,B,F}, row1 {7,8,9,E}, row2 {4,5,6,D}, row3 {1,2,3,C}, listed column 0..3; other sizes use code = row*COLS+col.
REQ-026 Keys pressed in other columns during HOLD/RELEASE_DB SHALL be ignored (column not driven).
REQ-027 Counters SHALL saturate, never wrap; SCAN_DIV counter width $clog2(SCAN_DIV), debounce counter width $clog2(DEBOUNCE_CYCLES+1).

Reset
REQ-028 Reset SHALL force state SCAN, col_drive = bit 0 set, counters 0, key_code 0, history 0, key_valid 0, multi_key 0, busy 0, synchronizer flops 0.
REQ-029 Reset asserted mid-debounce or mid-hold SHALL take effect next edge with no key_valid emitted.

Structure
REQ-030 Package keypad_pkg SHALL hold the state enum, KEYMAP constant table and key-code width constant.
REQ-031 Sub-module debounce_counter (clear, enable, parameter LIMIT, done output) SHALL be instantiated once and shared by PRESS_DB and RELEASE_DB.

Verification
REQ-032 Reset, no press, SCAN_DIV=4, COLS=4 -> col_drive 0001,0010,0100,1000,0001 every 4 cycles.
REQ-033 Row 1 held in column 2 longer than DEBOUNCE_CYCLES -> single key_valid, key_code=9, history[3:0]=9.
REQ-034 Row 0 bounces for DEBOUNCE_CYCLES-1 cycles then releases -> no key_valid, FSM back to SCAN, same column.
REQ-035 Sequential presses 1,2,3 with HIST_DEPTH=2 -> history = {2,3}, three key_valid pulses.
REQ-036 Rows 0 and 2 together stable in column 0 -> multi_key pulse, no key_valid, history unchanged.
REQ-037 Reset during HOLD -> next cycle state SCAN, col_drive=0001, history=0, no pulses.
